// File: rtl/iq_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iq_adc_pkg
// Description : Shared widths, default mux channels and FSM states for the
//               I/Q ADC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package iq_adc_pkg;

    localparam int ADC_W = 12;
    localparam int CH_W  = 3;

    localparam logic [CH_W-1:0] CH_I_DEF = 3'b100;
    localparam logic [CH_W-1:0] CH_Q_DEF = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SOC_I  = 3'd1,
        ST_WAIT_I = 3'd2,
        ST_SOC_Q  = 3'd3,
        ST_WAIT_Q = 3'd4
    } iq_state_t;

endpackage
`default_nettype wire

// File: rtl/eoc_sync.sv
`default_nettype none
// ============================================================================
// Module      : eoc_sync
// Description : Two-flop synchroniser plus rising-edge detect for an
//               ADC-clock-domain end-of-conversion strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module eoc_sync (
    input  logic clk,
    input  logic RSTn,
    input  logic async_in,
    output logic pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign pulse = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/iq_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : iq_adc_sequencer
// Description : Periodic I-then-Q conversion scheduler for the shared SAR
//               ADC with valid/ready output. Optional EOC watchdog is built
//               when IQ_SEQ_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_adc_sequencer
    import iq_adc_pkg::*;
#(
    parameter logic [CH_W-1:0] CH_I       = CH_I_DEF,
    parameter logic [CH_W-1:0] CH_Q       = CH_Q_DEF,
    parameter int              SOC_CYCLES = 8,
    parameter int              TIMEOUT    = 1023
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             enable,
    input  logic [15:0]      period,
    output logic             adc_soc,
    output logic [CH_W-1:0]  adc_s,
    input  logic             adc_eoc,
    input  logic [ADC_W-1:0] adc_dout,
    output logic [ADC_W-1:0] i_data,
    output logic [ADC_W-1:0] q_data,
    output logic             iq_valid,
    input  logic             iq_ready,
    output logic             busy,
    output logic             overrun,
    output logic             timeout_err
);

    localparam logic [7:0]  c_SOC_LAST = 8'(SOC_CYCLES - 1);
    localparam logic [15:0] c_WD_LAST  = 16'(TIMEOUT - 1);

    iq_state_t        r_state;
    iq_state_t        w_state_next;
    logic [15:0]      r_trig_cnt;
    logic [7:0]       r_soc_cnt;
    logic             r_en_d;
    logic [CH_W-1:0]  r_adc_s;
    logic [ADC_W-1:0] r_i_shadow;
    logic [ADC_W-1:0] r_i_data;
    logic [ADC_W-1:0] r_q_data;
    logic             r_iq_valid;
    logic             r_overrun;
    logic             w_trig;
    logic             w_eoc_pulse;
    logic             w_in_soc;
    logic             w_soc_done;
    logic             w_wd_expire;
    logic             w_en_rise;

    eoc_sync u_eoc_sync (
        .clk      (clk),
        .RSTn     (RSTn),
        .async_in (adc_eoc),
        .pulse    (w_eoc_pulse)
    );

    // Counter saturates into a wrap even if period is lowered mid-count
    assign w_trig    = enable && (r_trig_cnt >= period);
    assign w_en_rise = enable && !r_en_d;
    assign w_in_soc  = (r_state == ST_SOC_I) || (r_state == ST_SOC_Q);
    assign w_soc_done = w_in_soc && (r_soc_cnt == c_SOC_LAST);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_trig_cnt <= 16'd0;
            r_en_d     <= 1'b0;
        end else begin
            r_en_d <= enable;
            if (!enable || w_trig) r_trig_cnt <= 16'd0;
            else                   r_trig_cnt <= r_trig_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_trig && !r_iq_valid) w_state_next = ST_SOC_I;
            ST_SOC_I:  if (w_soc_done)            w_state_next = ST_WAIT_I;
            ST_WAIT_I: if (w_eoc_pulse)           w_state_next = ST_SOC_Q;
            ST_SOC_Q:  if (w_soc_done)            w_state_next = ST_WAIT_Q;
            ST_WAIT_Q: if (w_eoc_pulse)           w_state_next = ST_IDLE;
            default:                              w_state_next = ST_IDLE;
        endcase
        if (w_wd_expire) w_state_next = ST_IDLE;
    end

    always_comb begin
        adc_soc = w_in_soc;
        busy    = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) r_soc_cnt <= 8'd0;
        else if (w_in_soc && (w_state_next == r_state)) r_soc_cnt <= r_soc_cnt + 8'd1;
        else r_soc_cnt <= 8'd0;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_adc_s    <= CH_I;
            r_i_shadow <= '0;
            r_i_data   <= '0;
            r_q_data   <= '0;
            r_iq_valid <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_state_next == ST_SOC_I) r_adc_s <= CH_I;
            if (r_state == ST_WAIT_I && w_state_next == ST_SOC_Q) begin
                r_i_shadow <= adc_dout;
                r_adc_s    <= CH_Q;
            end
            if (r_state == ST_WAIT_Q && w_eoc_pulse && !w_wd_expire) begin
                r_i_data   <= r_i_shadow;
                r_q_data   <= adc_dout;
                r_iq_valid <= 1'b1;
            end else if (r_iq_valid && iq_ready) begin
                r_iq_valid <= 1'b0;
            end
        end
    end

    // A trigger arriving while the slot is busy is dropped and flagged
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) r_overrun <= 1'b0;
        else if (w_trig && ((r_state != ST_IDLE) || r_iq_valid)) r_overrun <= 1'b1;
        else if (w_en_rise) r_overrun <= 1'b0;
    end

`ifdef IQ_SEQ_TIMEOUT_EN
    logic [15:0] r_wd_cnt;
    logic        r_timeout_err;

    // Restarts at every SOC rise: zero in the first SOC_x cycle
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) r_wd_cnt <= 16'd0;
        else if (r_state == ST_IDLE || (r_state == ST_WAIT_I && w_state_next == ST_SOC_Q))
            r_wd_cnt <= 16'd0;
        else
            r_wd_cnt <= r_wd_cnt + 16'd1;
    end

    assign w_wd_expire = (r_state != ST_IDLE) && (r_wd_cnt == c_WD_LAST);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) r_timeout_err <= 1'b0;
        else if (w_wd_expire) r_timeout_err <= 1'b1;
        else if (w_en_rise) r_timeout_err <= 1'b0;
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^c_WD_LAST;
    assign w_wd_expire      = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    assign adc_s    = r_adc_s;
    assign i_data   = r_i_data;
    assign q_data   = r_q_data;
    assign iq_valid = r_iq_valid;
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_iq_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_adc_sequencer
// Description : Self-checking bench with a behavioural ADC model and
//               pair/overrun/timing expectations derived from the scheduler
//               rules. Timeout checks follow IQ_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_adc_sequencer;

    localparam logic [2:0] C_CH_I = 3'b100;
    localparam logic [2:0] C_CH_Q = 3'b110;
    localparam int C_SOC = 8;
    localparam int C_TO  = 1023;

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] period = 16'd999;
    logic        adc_soc;
    logic [2:0]  adc_s;
    logic        adc_eoc;
    logic [11:0] adc_dout;
    logic [11:0] i_data;
    logic [11:0] q_data;
    logic        iq_valid;
    logic        iq_ready = 1'b1;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    iq_adc_sequencer dut (
        .clk(clk), .RSTn(RSTn), .enable(enable), .period(period),
        .adc_soc(adc_soc), .adc_s(adc_s), .adc_eoc(adc_eoc), .adc_dout(adc_dout),
        .i_data(i_data), .q_data(q_data), .iq_valid(iq_valid), .iq_ready(iq_ready),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // ---------------- ADC model and observers ----------------
    logic [11:0] val_ch [8];
    bit          never_eoc = 1'b0;
    int          conv_time = 40;
    int          conv_left, hold_left, soc_w, toggle_err;
    logic        soc_prev;
    logic [2:0]  soc_ch, pend_ch;
    int          soc_w_q[$];
    logic [2:0]  ch_q[$];
    int          soc_rise_q[$];

    int          cyc = 0;
    logic        acc_q = 1'b0;
    logic [11:0] got_i[$];
    logic [11:0] got_q[$];
    int          valid_rise_q[$];
    int          stab_err, hs_err, ov_rise, te_rise;
    logic        val_prev, ov_prev, te_prev;
    logic [11:0] hold_i, hold_q;

    initial begin
        adc_eoc = 1'b0; adc_dout = 12'd0; soc_prev = 1'b0;
        conv_left = 0; hold_left = 0; soc_w = 0; toggle_err = 0;
        forever begin
            @(negedge clk);
            if (adc_soc && !soc_prev) begin
                soc_ch = adc_s; soc_w = 1; soc_rise_q.push_back(cyc);
            end else if (adc_soc) begin
                soc_w++;
                if (adc_s !== soc_ch) toggle_err++;
            end else if (soc_prev) begin
                soc_w_q.push_back(soc_w);
                ch_q.push_back(soc_ch);
                if (!never_eoc) begin conv_left = conv_time; pend_ch = soc_ch; end
            end
            soc_prev = adc_soc;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) begin adc_eoc = 1'b0; adc_dout = 12'($urandom); end
            end else if (conv_left > 0) begin
                conv_left--;
                if (conv_left == 0) begin adc_eoc = 1'b1; adc_dout = val_ch[pend_ch]; hold_left = 5; end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        acc_q = iq_valid && iq_ready;
    end

    initial begin
        val_prev = 1'b0; ov_prev = 1'b0; te_prev = 1'b0;
        stab_err = 0; hs_err = 0; ov_rise = -1; te_rise = -1;
        forever begin
            @(negedge clk);
            if (iq_valid && !val_prev) begin
                got_i.push_back(i_data); got_q.push_back(q_data); valid_rise_q.push_back(cyc);
            end
            if (iq_valid && val_prev && (i_data !== hold_i || q_data !== hold_q)) stab_err++;
            if (acc_q && iq_valid) hs_err++;
            if (overrun && !ov_prev) ov_rise = cyc;
            if (timeout_err && !te_prev) te_rise = cyc;
            val_prev = iq_valid; ov_prev = overrun; te_prev = timeout_err;
            hold_i = i_data; hold_q = q_data;
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic clear_obs();
        soc_w_q.delete(); ch_q.delete(); soc_rise_q.delete();
        got_i.delete(); got_q.delete(); valid_rise_q.delete();
        toggle_err = 0; stab_err = 0; hs_err = 0; ov_rise = -1; te_rise = -1;
    endtask

    task automatic new_values();
        for (int c = 0; c < 8; c++) val_ch[c] = 12'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RSTn = 1'b0; enable = 1'b0; iq_ready = 1'b1;
        conv_left = 0; hold_left = 0; adc_eoc = 1'b0;
        repeat (3) @(negedge clk);
        RSTn = 1'b1;
        clear_obs();
    endtask

    task automatic drain();
        @(negedge clk);
        enable = 1'b0; iq_ready = 1'b1;
        repeat (200) @(negedge clk);
        clear_obs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        RSTn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({adc_soc, adc_s, iq_valid, busy, overrun, timeout_err} !== {1'b0, C_CH_I, 4'b0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: soc=%b s=%b v=%b busy=%b ov=%b to=%b, need 0 100 0 0 0 0",
                     adc_soc, adc_s, iq_valid, busy, overrun, timeout_err);
        end
        n_checks++;
        if ({i_data, q_data} !== 24'd0) begin
            n_fail++; $display("FAIL reset_data: i=%h q=%h, need 000 000", i_data, q_data);
        end
        RSTn = 1'b1;
        clear_obs();
    endtask

    task automatic test_periodic();
        new_values(); conv_time = 20 + int'($urandom_range(40));
        period = 16'd999; iq_ready = 1'b1;
        @(negedge clk); enable = 1'b1;
        for (int k = 0; k < 4000 && got_i.size() < 3; k++) @(negedge clk);
        n_checks++;
        if (got_i.size() < 3) begin
            n_fail++; $display("FAIL periodic_count: got %0d pairs, need 3", got_i.size());
        end else begin
            for (int p = 0; p < 3; p++) begin
                n_checks++;
                if (got_i[p] !== val_ch[C_CH_I] || got_q[p] !== val_ch[C_CH_Q]) begin
                    n_fail++;
                    $display("FAIL periodic_data[%0d]: i=%h q=%h, need %h %h", p, got_i[p], got_q[p],
                             val_ch[C_CH_I], val_ch[C_CH_Q]);
                end
            end
            for (int p = 1; p < 3; p++) begin
                n_checks++;
                if (valid_rise_q[p] - valid_rise_q[p-1] != 1000) begin
                    n_fail++; $display("FAIL periodic_spacing[%0d]: %0d cycles, need 1000", p,
                                       valid_rise_q[p] - valid_rise_q[p-1]);
                end
            end
        end
        for (int k = 0; k < soc_w_q.size(); k++) begin
            n_checks++;
            if (soc_w_q[k] != C_SOC || ch_q[k] !== ((k % 2 == 0) ? C_CH_I : C_CH_Q)) begin
                n_fail++; $display("FAIL soc_shape[%0d]: width=%0d ch=%b, need %0d %b", k, soc_w_q[k],
                                   ch_q[k], C_SOC, (k % 2 == 0) ? C_CH_I : C_CH_Q);
            end
        end
        n_checks++;
        if (toggle_err != 0 || hs_err != 0 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL periodic_status: toggles=%0d hs_err=%0d overrun=%b, need 0 0 0",
                               toggle_err, hs_err, overrun);
        end
    endtask

    task automatic test_backpressure();
        drain();
        new_values(); iq_ready = 1'b0; period = 16'd999;
        enable = 1'b1;
        for (int k = 0; k < 1500 && got_i.size() < 1; k++) @(negedge clk);
        for (int k = 0; k < 1200 && ov_rise < 0; k++) @(negedge clk);
        n_checks++;
        if (got_i.size() != 1 || soc_rise_q.size() < 1 || ov_rise < 0) begin
            n_fail++; $display("FAIL bp_events: pairs=%0d socs=%0d ov_rise=%0d, need 1 >=1 >=0",
                               got_i.size(), soc_rise_q.size(), ov_rise);
        end else begin
            n_checks++;
            if (ov_rise - soc_rise_q[0] != 1000) begin
                n_fail++; $display("FAIL bp_overrun_time: %0d cycles after SOC, need 1000",
                                   ov_rise - soc_rise_q[0]);
            end
        end
        n_checks++;
        if (iq_valid !== 1'b1 || i_data !== val_ch[C_CH_I] || q_data !== val_ch[C_CH_Q] || stab_err != 0) begin
            n_fail++; $display("FAIL bp_hold: v=%b i=%h q=%h stab_err=%0d, need 1 %h %h 0", iq_valid,
                               i_data, q_data, stab_err, val_ch[C_CH_I], val_ch[C_CH_Q]);
        end
        iq_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (iq_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_accept: iq_valid=%b one cycle after accept, need 0", iq_valid);
        end
    endtask

    task automatic test_overrun_fast();
        drain();
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++; $display("FAIL ov_sticky: overrun=%b, need 1", overrun);
        end
        new_values(); conv_time = 40; period = 16'd10;
        enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++; $display("FAIL ov_clear: overrun=%b after enable rise, need 0", overrun);
        end
        for (int k = 0; k < 2000 && got_i.size() < 4; k++) @(negedge clk);
        n_checks++;
        if (got_i.size() < 4 || overrun !== 1'b1 || toggle_err != 0) begin
            n_fail++; $display("FAIL fast_status: pairs=%0d overrun=%b toggles=%0d, need 4 1 0",
                               got_i.size(), overrun, toggle_err);
        end
        for (int p = 0; p < got_i.size(); p++) begin
            n_checks++;
            if (got_i[p] !== val_ch[C_CH_I] || got_q[p] !== val_ch[C_CH_Q]) begin
                n_fail++; $display("FAIL fast_data[%0d]: i=%h q=%h, need %h %h", p, got_i[p], got_q[p],
                                   val_ch[C_CH_I], val_ch[C_CH_Q]);
            end
        end
        // period 0: next pair starts two cycles after iq_valid rises (ready held high)
        clear_obs(); period = 16'd0;
        for (int k = 0; k < 1000 && valid_rise_q.size() < 2; k++) @(negedge clk);
        n_checks++;
        if (valid_rise_q.size() < 2) begin
            n_fail++; $display("FAIL p0_count: pairs=%0d, need 2", valid_rise_q.size());
        end else begin
            int first_soc;
            first_soc = -1;
            foreach (soc_rise_q[k]) if (first_soc < 0 && soc_rise_q[k] > valid_rise_q[0]) first_soc = soc_rise_q[k];
            n_checks++;
            if (first_soc - valid_rise_q[0] != 2) begin
                n_fail++; $display("FAIL p0_restart: SOC %0d cycles after valid, need 2",
                                   first_soc - valid_rise_q[0]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        never_eoc = 1'b1; period = 16'd20;
        enable = 1'b1;
`ifdef IQ_SEQ_TIMEOUT_EN
        for (int k = 0; k < 1500 && timeout_err !== 1'b1; k++) @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b1 || soc_rise_q.size() < 1) begin
            n_fail++; $display("FAIL to_flag: timeout_err=%b, need 1", timeout_err);
        end else begin
            n_checks++;
            if (te_rise - soc_rise_q[0] != C_TO || busy !== 1'b0 || iq_valid !== 1'b0 || adc_soc !== 1'b0) begin
                n_fail++; $display("FAIL to_state: delay=%0d busy=%b v=%b soc=%b, need %0d 0 0 0",
                                   te_rise - soc_rise_q[0], busy, iq_valid, adc_soc, C_TO);
            end
        end
`else
        repeat (1500) @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1 || iq_valid !== 1'b0) begin
            n_fail++; $display("FAIL no_watchdog: to=%b busy=%b v=%b, need 0 1 0", timeout_err, busy, iq_valid);
        end
`endif
        enable = 1'b0; never_eoc = 1'b0;
    endtask

    task automatic test_reset_midconv();
        do_reset();
        new_values(); conv_time = 60; period = 16'd30; iq_ready = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 500 && !(adc_s === C_CH_Q && adc_soc === 1'b0 && busy === 1'b1); k++) @(negedge clk);
        #2;
        RSTn = 1'b0; enable = 1'b0;
        #1;
        n_checks++;
        if ({adc_soc, adc_s, iq_valid, busy, overrun, i_data, q_data} !== {1'b0, C_CH_I, 3'b0, 24'd0}) begin
            n_fail++; $display("FAIL midreset_now: soc=%b s=%b v=%b busy=%b ov=%b i=%h q=%h, need reset values",
                               adc_soc, adc_s, iq_valid, busy, overrun, i_data, q_data);
        end
        repeat (2) @(negedge clk);
        RSTn = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++;
        if (got_i.size() != 0 || {adc_soc, adc_s, iq_valid, busy, i_data, q_data} !== {1'b0, C_CH_I, 2'b0, 24'd0}) begin
            n_fail++; $display("FAIL stale_eoc: pairs=%0d soc=%b s=%b v=%b busy=%b i=%h q=%h, need reset values",
                               got_i.size(), adc_soc, adc_s, iq_valid, busy, i_data, q_data);
        end
        enable = 1'b1;
        for (int k = 0; k < 100 && adc_soc !== 1'b1; k++) @(negedge clk);
        n_checks++;
        if (adc_soc !== 1'b1 || adc_s !== C_CH_I) begin
            n_fail++; $display("FAIL restart_ch: soc=%b s=%b, need 1 %b", adc_soc, adc_s, C_CH_I);
        end
        enable = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < 8; c++) val_ch[c] = 12'd0;
        test_reset();
        test_periodic();
        test_backpressure();
        test_overrun_fast();
        test_timeout();
        test_reset_midconv();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
